// File: rtl/cap_seq_pkg.sv
// Shared definitions for the capture sequencer: FSM state encoding and default sizing.
package cap_seq_pkg;

  localparam int LEN_W_DEF    = 16;
  localparam int MRST_CYC_DEF = 8;
  localparam int TOUT_CYC_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MRST     = 3'd1,
    FIRE     = 3'd2,
    WAIT_RDY = 3'd3,
    CAPT     = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/cap_trig_edge.sv
// Rising-edge detector for the capture trigger level; the history bit resets to 0
// so a level already high at reset release is seen as an edge.
module cap_trig_edge (
  input  logic clk62,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  always_ff @(posedge clk62 or negedge rst_n) begin
    if (!rst_n) r_sig_q <= 1'b0;
    else        r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/cap_seq_ctrl.sv
// Capture sequencer: memory reset, laser fire, wait for driver ready, count merged words.
// Optional lddr_rdy timeout is built only when CAP_TIMEOUT_EN is defined.
module cap_seq_ctrl
  import cap_seq_pkg::*;
#(
  parameter int LEN_W    = LEN_W_DEF,
  parameter int MRST_CYC = MRST_CYC_DEF,
  parameter int TOUT_CYC = TOUT_CYC_DEF
) (
  input  logic             clk62,
  input  logic             rst_n,
  input  logic             cap_trig,
  input  logic [LEN_W-1:0] cap_len,
  input  logic             cap_abort,
  input  logic             lddr_rdy,
  input  logic             mereg_datv,
  output logic             mem_reset,
  output logic             ldd_trig,
  output logic             merge_en,
  output logic             cap_busy,
  output logic             capr_rdy,
  output logic             cap_err,
  output logic [LEN_W-1:0] cap_cnt
);

  localparam int MC_W = $clog2(MRST_CYC + 1);

  state_t           r_state, w_nxt;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [MC_W-1:0]  r_mcnt;
  logic             w_rise, w_accept, w_count;
  logic             r_mem_reset, r_ldd_trig, r_merge_en, r_cap_busy, r_capr_rdy;

`ifdef CAP_TIMEOUT_EN
  localparam int TC_W = $clog2(TOUT_CYC + 1);
  logic [TC_W-1:0] r_tcnt;
  logic            r_err, w_tout;
`endif

  cap_trig_edge u_edge (
    .clk62 (clk62),
    .rst_n (rst_n),
    .i_sig (cap_trig),
    .o_rise(w_rise)
  );

  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_count  = 1'b0;
`ifdef CAP_TIMEOUT_EN
    w_tout   = 1'b0;
`endif
    case (r_state)
      IDLE:     if (w_rise && cap_len != '0) begin
                  w_accept = 1'b1;
                  w_nxt    = MRST;
                end
      MRST:     if (r_mcnt == MC_W'(MRST_CYC - 1)) w_nxt = FIRE;
      FIRE:     w_nxt = WAIT_RDY;
      WAIT_RDY: if (lddr_rdy) w_nxt = CAPT;
`ifdef CAP_TIMEOUT_EN
                else if (r_tcnt == TC_W'(TOUT_CYC - 1)) begin
                  w_tout = 1'b1;
                  w_nxt  = DONE;
                end
`endif
      CAPT:     if (mereg_datv) begin
                  w_count = (r_cnt < r_len);
                  if (r_cnt >= r_len - LEN_W'(1)) w_nxt = DONE;
                end
      DONE:     w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
    // Abort wins over every transition, including the final word and a timeout.
    if (cap_abort && r_state != IDLE) begin
      w_nxt   = IDLE;
      w_count = 1'b0;
`ifdef CAP_TIMEOUT_EN
      w_tout  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk62 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_mcnt      <= '0;
      r_mem_reset <= 1'b0;
      r_ldd_trig  <= 1'b0;
      r_merge_en  <= 1'b0;
      r_cap_busy  <= 1'b0;
      r_capr_rdy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_len  <= cap_len;
        r_cnt  <= '0;
        r_mcnt <= '0;
      end else begin
        if (w_count)           r_cnt  <= r_cnt + LEN_W'(1);
        if (r_state == MRST)   r_mcnt <= r_mcnt + MC_W'(1);
      end
      // Outputs are registered decodes of the next state.
      r_mem_reset <= (w_nxt == MRST);
      r_ldd_trig  <= (w_nxt == FIRE);
      r_merge_en  <= (w_nxt == CAPT);
      r_cap_busy  <= (w_nxt != IDLE);
      r_capr_rdy  <= (w_nxt == DONE);
    end
  end

`ifdef CAP_TIMEOUT_EN
  always_ff @(posedge clk62 or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == FIRE)          r_tcnt <= '0;
      else if (r_state == WAIT_RDY) r_tcnt <= r_tcnt + TC_W'(1);
      if (w_accept)    r_err <= 1'b0;
      else if (w_tout) r_err <= 1'b1;
    end
  end

  assign cap_err = r_err;
`else
  assign cap_err = 1'b0;
`endif

  assign mem_reset = r_mem_reset;
  assign ldd_trig  = r_ldd_trig;
  assign merge_en  = r_merge_en;
  assign cap_busy  = r_cap_busy;
  assign capr_rdy  = r_capr_rdy;
  assign cap_cnt   = r_cnt;

endmodule
